radio_timing_engine: RTL
========================

Name: radio_timing_engine

Overview:
- Upstream stage of the radio-enable output register.
- Generates the timed radio_enable_synced / radio_rx_en_synced pair on the timing-engine interface, which the downstream stage re-registers.
- Sequences one radio activation per start request (warm-up, RX window, cool-down) using a 4-state FSM and cycle counters.
- Honours the isolation request from the M1 domain by forcing a clean, all-zero output state.

Parameters:
- WARMUP_CYC, 16, cycles radio_enable is high before the RX window opens (>=1).
- COOLDOWN_CYC, 8, cycles radio_enable stays high after the RX window closes (>=1).
- LEN_W, 12, width of the RX-window length request.

Ports:
- ck  input  1  clock.
- arst_n  input  1  asynchronous active-low reset.
- isolate_m1  input  1  level; high = M1 domain isolating, engine must go quiet.
- start  input  1  single-cycle request to run one activation.
- rx_len  input  LEN_W  RX window length in cycles; sampled only when start is accepted.
- abort  input  1  single-cycle request to terminate the current activation early.
- radio_enable_synced  output  1  registered radio enable to the downstream stage.
- radio_rx_en_synced  output  1  registered RX enable to the downstream stage.
- busy  output  1  high whenever FSM is not IDLE.
- done  output  1  one-cycle pulse when an activation finishes (normal or aborted).

Behaviour:
- Clock and reset: one clock, ck. Reset arst_n is asynchronous and active-low.
- Reset values: FSM = IDLE, counters = 0, latched length = 0, all outputs = 0.
- FSM states and outputs:
  - IDLE: enable = 0, rx_en = 0.
  - WARMUP: enable = 1, rx_en = 0.
  - RX: enable = 1, rx_en = 1.
  - COOLDOWN: enable = 1, rx_en = 0.
- All outputs are registered and decoded from the next state, so outputs change on the same edge as the state.
- Start acceptance:
  - start is accepted only in IDLE with isolate_m1 = 0 and abort = 0.
  - On acceptance at edge T, rx_len is latched, state = WARMUP and radio_enable_synced = 1 from T.
- WARMUP: lasts exactly WARMUP_CYC cycles. It then goes to RX, or directly to COOLDOWN if the latched length is 0. rx_en never pulses in that case.
- RX: lasts exactly latched-length cycles, then goes to COOLDOWN.
- COOLDOWN: lasts exactly COOLDOWN_CYC cycles, then goes to IDLE.
  - enable and busy drop and done = 1 for one cycle at the same edge.
- Timing: total enable-high duration is WARMUP_CYC + rx_len + COOLDOWN_CYC cycles.
- Counters:
  - One down-counter, width max(LEN_W, clog2 of each CYC parameter + 1).
  - Loaded on every state entry with (duration − 1). State exits when count = 0.
  - No wrap-around is possible. rx_len = 2^LEN_W − 1 must work.
- start while busy: ignored, with no effect on the latched length.
- abort:
  - In WARMUP or RX: next state is COOLDOWN, rx_en drops on that edge, and the full COOLDOWN_CYC is run.
  - In COOLDOWN: ignored; cool-down completes.
  - In IDLE: no effect. If it coincides with start, abort wins and start is dropped.
- isolate_m1 high, sampled at any edge:
  - FSM goes to IDLE immediately and both enables are 0 on that edge.
  - No cool-down is run. done pulses once if the FSM was not IDLE.
  - While isolate_m1 stays high, start is ignored.
  - isolate_m1 takes priority over abort and start.
- Reset mid-operation: all outputs are 0 asynchronously and no done pulse is produced.
- Output invariant: radio_rx_en_synced = 1 implies radio_enable_synced = 1, on every cycle.

Test Plan:
- Nominal activation: WARMUP_CYC = 16, COOLDOWN_CYC = 8, start with rx_len = 5 → enable high 29 cycles, rx_en high cycles 17–21 after the start edge, done pulse on the enable falling edge, busy high 29 cycles.
- Zero-length RX window: start with rx_len = 0 → enable high 24 cycles, rx_en never asserts, single done pulse.
- Abort in RX: rx_len = 100, abort on the 10th RX cycle → rx_en falls on that edge, enable stays high 8 more cycles, done once; a start issued during the cooldown is ignored.
- Isolation mid-WARMUP: isolate_m1 raised on warm-up cycle 4 → both enables 0 on the same edge, done pulses once; start held while isolated does nothing; start after isolation drops runs a full activation.
- Priority and edge cases in IDLE: start + abort in the same cycle → stays IDLE. rx_len = 4095 → rx_en high exactly 4095 cycles.
- Asynchronous reset: arst_n low mid-RX → outputs 0 without a clock edge, no done pulse, FSM IDLE after release.
- Throughout all tests: invariant assertion that rx_en implies enable.

Source files
------------

// File: rtl/radio_timing_engine.sv
// radio_timing_engine: sequences one warm-up / RX / cool-down radio activation per start request.
module radio_timing_engine #(
  parameter int WARMUP_CYC   = 16,
  parameter int COOLDOWN_CYC = 8,
  parameter int LEN_W        = 12
) (
  input  logic             ck,
  input  logic             arst_n,
  input  logic             isolate_m1,
  input  logic             start,
  input  logic [LEN_W-1:0] rx_len,
  input  logic             abort,
  output logic             radio_enable_synced,
  output logic             radio_rx_en_synced,
  output logic             busy,
  output logic             done
);
  localparam int WW    = $clog2(WARMUP_CYC) + 1;
  localparam int CW    = $clog2(COOLDOWN_CYC) + 1;
  localparam int MW    = (WW > CW) ? WW : CW;
  localparam int CNT_W = (LEN_W > MW) ? LEN_W : MW;
  localparam logic [CNT_W-1:0] WARM_LD = CNT_W'(WARMUP_CYC - 1);
  localparam logic [CNT_W-1:0] COOL_LD = CNT_W'(COOLDOWN_CYC - 1);
  typedef enum logic [1:0] {IDLE, WARMUP, RX, COOLDOWN} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             en_q, en_d, rx_q, rx_d, done_q, done_d;
  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      en_q    <= 1'b0;
      rx_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      en_q    <= en_d;
      rx_q    <= rx_d;
      done_q  <= done_d;
    end
  end
  // Counter holds (duration - 1) on state entry; a state exits when it reaches zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CNT_W'(1);
    len_d   = len_q;
    if (isolate_m1) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (start && !abort) begin
            state_d = WARMUP;
            cnt_d   = WARM_LD;
            len_d   = rx_len;
          end
        end
        WARMUP: begin
          if (abort || (cnt_q == '0 && len_q == '0)) begin
            state_d = COOLDOWN;
            cnt_d   = COOL_LD;
          end else if (cnt_q == '0) begin
            state_d = RX;
            cnt_d   = CNT_W'(len_q) - CNT_W'(1);
          end
        end
        RX: begin
          if (abort || cnt_q == '0) begin
            state_d = COOLDOWN;
            cnt_d   = COOL_LD;
          end
        end
        COOLDOWN: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end
  always_comb begin
    en_d   = state_d != IDLE;
    rx_d   = state_d == RX;
    done_d = (state_q != IDLE) && (state_d == IDLE);
  end
  assign radio_enable_synced = en_q;
  assign radio_rx_en_synced  = rx_q;
  assign busy                = state_q != IDLE;
  assign done                = done_q;
endmodule
